wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the in-order pipeline
// (default priority) and the multicycle mul/div unit, with a starvation guard.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT      = 4,
    // Value loaded into the forced-grant counter on reset.
    parameter logic [15:0] STALL_COUNT_RESET = 16'h0000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_index_i,
    input  logic [31:0] wb_rd_value_i,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_index_i,
    input  logic [31:0] mdu_rd_value_i,
    output logic        mdu_ready_o,
    output logic        wb_stall_o,
    output logic        rd_we_o,
    output logic [4:0]  rd_index_o,
    output logic [31:0] rd_value_o,
    output logic [15:0] stall_count_o
);

    // Handshake: an MDU result transfers in a cycle with mdu_valid_i=1 and
    // mdu_ready_o=1; the MDU holds index/value stable until that cycle.
    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  wait_cnt;
    logic [2:0]  wait_next;
    logic        wb_live;
    logic        mdu_live;
    logic        grant_wb;
    logic        grant_mdu;

    assign wb_live    = wb_valid_i && (wb_rd_index_i != 5'd0);
    assign mdu_live   = mdu_valid_i && (mdu_rd_index_i != 5'd0);
    assign wb_stall_o = reset_n_i && (state == FORCE);

    always_comb begin
        state_next  = NORMAL;
        wait_next   = 3'd0;
        mdu_ready_o = 1'b0;
        grant_wb    = 1'b0;
        grant_mdu   = 1'b0;
        if (state == FORCE) begin
            mdu_ready_o = mdu_valid_i;
            grant_mdu   = mdu_live;
        end else if (wb_live) begin
            grant_wb = 1'b1;
            if (mdu_valid_i) begin
                if (({1'b0, wait_cnt} + 4'd1) == 4'(STARVE_LIMIT)) begin
                    state_next = FORCE;
                end else begin
                    wait_next = wait_cnt + 3'd1;
                end
            end
        end else begin
            mdu_ready_o = mdu_valid_i;
            grant_mdu   = mdu_live;
        end
        if (!reset_n_i) begin
            mdu_ready_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state         <= NORMAL;
            wait_cnt      <= 3'd0;
            rd_we_o       <= 1'b0;
            rd_index_o    <= 5'd0;
            rd_value_o    <= 32'd0;
            stall_count_o <= STALL_COUNT_RESET;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            rd_we_o  <= grant_wb || grant_mdu;
            if (grant_wb) begin
                rd_index_o <= wb_rd_index_i;
                rd_value_o <= wb_rd_value_i;
            end else if (grant_mdu) begin
                rd_index_o <= mdu_rd_index_i;
                rd_value_o <= mdu_rd_value_i;
            end else begin
                rd_index_o <= 5'd0;
                rd_value_o <= 32'd0;
            end
            if (state == FORCE && stall_count_o != 16'hFFFF) begin
                stall_count_o <= stall_count_o + 16'd1;
            end
        end
    end

endmodule
